// File: rtl/insight_trace_packetizer.sv
// Builds one timestamped trace record per core event cycle and streams records from a FIFO.
// Overflow is reported in-band by a marker record carrying the number of lost events.
module insight_trace_packetizer #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned DELTA_W = 16,
  parameter int unsigned DEPTH   = 8,
  localparam int unsigned REC_W  = DELTA_W + 5 + 2 * XLEN,
  localparam int unsigned PTR_W  = $clog2(DEPTH),
  localparam int unsigned LVL_W  = PTR_W + 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               commit,
  input  logic               exception,
  input  logic               interrupt_fire,
  input  logic               wfi,
  input  logic               cease,
  input  logic [XLEN-1:0]    pc,
  input  logic [XLEN-1:0]    data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [REC_W-1:0]   out_data,
  output logic [15:0]        drop_count,
  output logic               overflow_pending,
  output logic [LVL_W-1:0]   level
);

  localparam logic [LVL_W-1:0] LevelFull = LVL_W'(DEPTH);

  logic [REC_W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [DELTA_W-1:0] delta_q, delta_d;
  logic [15:0]        drop_q, drop_d;
  logic               pend_q, pend_d;

  logic [4:0]         flags;
  logic               event_cycle;
  logic               pop;
  logic               can_write;
  logic               wr_en;
  logic [REC_W-1:0]   wr_rec;

  assign out_valid        = (level_q != '0);
  assign out_data         = out_valid ? mem_q[rd_ptr_q] : '0;
  assign drop_count       = drop_q;
  assign overflow_pending = pend_q;
  assign level            = level_q;

  always_comb begin
    flags       = {cease, wfi, interrupt_fire, exception, commit};
    event_cycle = enable & (|flags);
    pop         = out_valid & out_ready;
    // Full FIFO still accepts a write when the head leaves on the same edge.
    can_write   = (level_q != LevelFull) | pop;
    wr_en       = 1'b0;
    wr_rec      = '0;
    drop_d      = drop_q;
    pend_d      = pend_q;

    if (pend_q && can_write) begin
      // Marker wins the slot; any coincident event starts the next drop tally.
      wr_en  = 1'b1;
      wr_rec = {delta_q, 5'b0, {XLEN{1'b0}}, {(XLEN - 16){1'b0}}, drop_q};
      drop_d = {15'b0, event_cycle};
      pend_d = event_cycle;
    end else if (event_cycle) begin
      if (can_write) begin
        wr_en  = 1'b1;
        wr_rec = {delta_q, flags, pc, data};
      end else begin
        drop_d = (&drop_q) ? drop_q : drop_q + 16'd1;
        pend_d = 1'b1;
      end
    end

    if (!enable || event_cycle) begin
      delta_d = '0;
    end else begin
      delta_d = (&delta_q) ? delta_q : delta_q + DELTA_W'(1);
    end

    unique case ({wr_en, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      delta_q  <= '0;
      drop_q   <= '0;
      pend_q   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_d;
      delta_q <= delta_d;
      drop_q  <= drop_d;
      pend_q  <= pend_d;
    end
  end

  // Storage needs no reset; out_data is masked while the FIFO is empty.
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_rec;
  end

endmodule
